// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory and decode handshake bundle for the fetch stage
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_req;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               decode_ready;

  modport master (
    output imem_addr, imem_req, instr, instr_pc, instr_valid,
    input  imem_ready, imem_rdata, decode_ready
  );

  modport slave (
    input  imem_addr, imem_req, instr, instr_pc, instr_valid,
    output imem_ready, imem_rdata, decode_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: word read at PC, instruction hold for decode, pc_step pulse, fault detect
module instr_fetch_unit #(
  parameter int ADDR_W   = 64,
  parameter int INSTR_W  = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PC,
  input  logic              fetch_en,
  input  logic              flush,
  output logic              pc_step,
  output logic [1:0]        fault_code,
  instr_fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      bus.imem_addr   <= '0;
      bus.imem_req    <= 1'b0;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
      pc_step         <= 1'b0;
      fault_code      <= 2'b00;
    end else begin
      pc_step <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush) begin
            if (fetch_en && PC[1:0] != 2'b00) begin
              fault_code <= 2'b01;
              state      <= FAULT;
            end else if (fetch_en) begin
              bus.imem_addr <= PC;
              bus.imem_req  <= 1'b1;
              wait_cnt      <= '0;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          // flush beats a same-cycle imem_ready so a redirected fetch never steps the PC
          if (flush) begin
            bus.imem_req <= 1'b0;
            state        <= IDLE;
          end else if (bus.imem_ready) begin
            bus.instr       <= bus.imem_rdata;
            bus.instr_pc    <= bus.imem_addr;
            bus.instr_valid <= 1'b1;
            bus.imem_req    <= 1'b0;
            pc_step         <= 1'b1;
            state           <= HOLD;
          end else if (wait_cnt == CNT_LAST) begin
            bus.imem_req <= 1'b0;
            fault_code   <= 2'b10;
            state        <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (flush || bus.decode_ready) begin
            bus.instr_valid <= 1'b0;
            state           <= IDLE;
          end
        end
        FAULT: begin
          bus.imem_req    <= 1'b0;
          bus.instr_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] PC;
  logic        fetch_en;
  logic        flush;
  logic        pc_step;
  logic [1:0]  fault_code;
  int          checks = 0;
  int          errors = 0;

  instr_fetch_unit_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

  instr_fetch_unit #(.ADDR_W(64), .INSTR_W(32), .WAIT_MAX(15)) dut (
    .clock      (clock),
    .reset      (reset),
    .PC         (PC),
    .fetch_en   (fetch_en),
    .flush      (flush),
    .pc_step    (pc_step),
    .fault_code (fault_code),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; fetch_en = 1'b0; flush = 1'b0; PC = '0;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0; bus.decode_ready = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || pc_step !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: req=%b valid=%b step=%b exp 0 0 0", bus.imem_req, bus.instr_valid, pc_step);
    end
    checks++;
    if (bus.imem_addr !== 64'h0 || bus.instr !== 32'h0 || bus.instr_pc !== 64'h0 || fault_code !== 2'b00) begin
      errors++; $display("FAIL reset_data: addr=%h instr=%h ipc=%h fault=%b exp all 0", bus.imem_addr, bus.instr, bus.instr_pc, fault_code);
    end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    PC = 64'h100; fetch_en = 1'b1; bus.decode_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h100) begin
        errors++; $display("FAIL basic_req%0d: req=%b addr=%h exp 1 100", i, bus.imem_req, bus.imem_addr);
      end
      if (i == 1) begin bus.imem_ready = 1'b1; bus.imem_rdata = 32'h8B020020; end
    end
    cyc();
    bus.imem_ready = 1'b0;
    checks++;
    if (bus.instr !== 32'h8B020020 || bus.instr_pc !== 64'h100 || bus.instr_valid !== 1'b1) begin
      errors++; $display("FAIL basic_instr: instr=%h ipc=%h valid=%b exp 8b020020 100 1", bus.instr, bus.instr_pc, bus.instr_valid);
    end
    checks++;
    if (pc_step !== 1'b1 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL basic_step: step=%b req=%b exp 1 0", pc_step, bus.imem_req);
    end
    PC = PC + 64'd4;
    cyc();
    checks++;
    if (bus.instr_valid !== 1'b0 || pc_step !== 1'b0) begin
      errors++; $display("FAIL basic_release: valid=%b step=%b exp 0 0", bus.instr_valid, pc_step);
    end
    cyc();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h104) begin
      errors++; $display("FAIL basic_next_addr: req=%b addr=%h exp 1 104", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_backpressure();
    int valid_cycles = 0;
    int step_pulses = 0;
    int hold_req = 0;
    int unstable = 0;
    do_reset();
    PC = 64'h180; fetch_en = 1'b1;
    cyc();
    fetch_en = 1'b0; bus.imem_ready = 1'b1; bus.imem_rdata = 32'hA5A5_0F0F;
    cyc();
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
    for (int i = 0; i < 6; i++) begin
      if (bus.instr_valid === 1'b1) begin
        valid_cycles++;
        if (bus.instr !== 32'hA5A5_0F0F || bus.instr_pc !== 64'h180) unstable++;
        if (bus.imem_req !== 1'b0) hold_req++;
      end
      if (pc_step === 1'b1) step_pulses++;
      bus.decode_ready = (i == 3);
      cyc();
    end
    checks++;
    if (valid_cycles != 4) begin
      errors++; $display("FAIL bp_valid_len: got %0d cycles exp 4", valid_cycles);
    end
    checks++;
    if (step_pulses != 1) begin
      errors++; $display("FAIL bp_step_count: got %0d pulses exp 1", step_pulses);
    end
    checks++;
    if (unstable != 0 || hold_req != 0) begin
      errors++; $display("FAIL bp_hold_stable: unstable=%0d req_in_hold=%0d exp 0 0", unstable, hold_req);
    end
  endtask

  task automatic test_flush_collision();
    do_reset();
    PC = 64'h120; fetch_en = 1'b1;
    cyc();
    fetch_en = 1'b0; flush = 1'b1; bus.imem_ready = 1'b1; bus.imem_rdata = 32'h1111_2222;
    cyc();
    flush = 1'b0; bus.imem_ready = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || pc_step !== 1'b0 || bus.imem_req !== 1'b0 || fault_code !== 2'b00) begin
      errors++; $display("FAIL flush_collision: valid=%b step=%b req=%b fault=%b exp 0 0 0 00", bus.instr_valid, pc_step, bus.imem_req, fault_code);
    end
    PC = 64'h140; fetch_en = 1'b1;
    cyc();
    fetch_en = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h140 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle_resume: req=%b addr=%h valid=%b exp 1 140 0", bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
  endtask

  task automatic test_misaligned();
    int bad = 0;
    do_reset();
    PC = 64'h102; fetch_en = 1'b1;
    cyc();
    checks++;
    if (fault_code !== 2'b01 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL misalign_fault: fault=%b req=%b exp 01 0", fault_code, bus.imem_req);
    end
    for (int i = 0; i < 6; i++) begin
      fetch_en = i[0]; flush = (i == 3); PC = 64'h100;
      cyc();
      if (fault_code !== 2'b01 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL misalign_sticky: got %0d bad cycles exp 0", bad);
    end
    do_reset();
    checks++;
    if (fault_code !== 2'b00) begin
      errors++; $display("FAIL misalign_clear: fault=%b exp 00", fault_code);
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    do_reset();
    PC = 64'h200; fetch_en = 1'b1;
    cyc();
    fetch_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req === 1'b1) req_cycles++;
      cyc();
    end
    checks++;
    if (req_cycles != 15) begin
      errors++; $display("FAIL timeout_req_len: got %0d cycles exp 15", req_cycles);
    end
    checks++;
    if (fault_code !== 2'b10 || bus.imem_req !== 1'b0 || pc_step !== 1'b0) begin
      errors++; $display("FAIL timeout_fault: fault=%b req=%b step=%b exp 10 0 0", fault_code, bus.imem_req, pc_step);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    PC = 64'h300; fetch_en = 1'b1;
    cyc();
    fetch_en = 1'b0; bus.imem_ready = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    cyc();
    bus.imem_ready = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL midrst_hold: valid=%b instr=%h exp 1 deadbeef", bus.instr_valid, bus.instr);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0 || pc_step !== 1'b0 || bus.instr_pc !== 64'h0) begin
      errors++; $display("FAIL midrst_clear: valid=%b instr=%h step=%b ipc=%h exp 0 0 0 0", bus.instr_valid, bus.instr, pc_step, bus.instr_pc);
    end
    PC = 64'h304; fetch_en = 1'b1; bus.decode_ready = 1'b1;
    cyc();
    fetch_en = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h304) begin
      errors++; $display("FAIL midrst_resume_req: req=%b addr=%h exp 1 304", bus.imem_req, bus.imem_addr);
    end
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h1234_5678;
    cyc();
    bus.imem_ready = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h1234_5678 || bus.instr_pc !== 64'h304 || pc_step !== 1'b1) begin
      errors++; $display("FAIL midrst_resume_instr: valid=%b instr=%h ipc=%h step=%b exp 1 12345678 304 1", bus.instr_valid, bus.instr, bus.instr_pc, pc_step);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_flush_collision();
    test_misaligned();
    test_timeout();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter. Takes the current PC and issues a word read to instruction memory.
- Latches the returned instruction for decode, with a valid/ready handshake.
- Pulses pc_step so the PC controller selects "PC <= PC+4" (PS=01) exactly once per accepted instruction.
- Detects misaligned PCs and memory timeouts.

Parameters:
- ADDR_W, 64, PC/address width.
- INSTR_W, 32, instruction width.
- WAIT_MAX, 15, max cycles in REQ without imem_ready before a timeout fault. Range 1..255.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
- PC  input  ADDR_W  current PC from the program counter.
- fetch_en  input  1  permits a new fetch to start.
- flush  input  1  branch redirect; discards the in-flight or held instruction.
- imem_addr  output  ADDR_W  memory read address.
- imem_req  output  1  memory read request.
- imem_ready  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  INSTR_W  memory read data.
- instr  output  INSTR_W  fetched instruction.
- instr_pc  output  ADDR_W  address of instr.
- instr_valid  output  1  instr/instr_pc valid for decode.
- decode_ready  input  1  decode accepts instr this cycle.
- pc_step  output  1  one-cycle pulse requesting PC+4.
- fault_code  output  2  00 none, 01 misaligned, 10 timeout; sticky.

Behaviour:
- All outputs are registered; no combinational input-to-output paths.
- Reset (sync, active-high, overrides everything, including mid-request): state=IDLE. imem_addr, instr, instr_pc = 0. imem_req, instr_valid, pc_step = 0. fault_code=00. Wait counter=0.
- States: IDLE, REQ, HOLD, FAULT.
- IDLE:
  - flush has priority: stay in IDLE.
  - Else if fetch_en and PC[1:0]!=00: go to FAULT, fault_code<=01.
  - Else if fetch_en: imem_addr<=PC, imem_req<=1, counter<=0, go to REQ.
- REQ: imem_req held at 1 and imem_addr stable until exit.
  - flush (wins even if imem_ready=1 in the same cycle): data dropped, imem_req<=0, no pc_step, go to IDLE.
  - Else if imem_ready: instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, imem_req<=0, pc_step<=1, go to HOLD.
  - Else if counter==WAIT_MAX-1: imem_req<=0, fault_code<=10, go to FAULT.
  - Else counter<=counter+1.
- HOLD: instr_valid=1; instr and instr_pc stable.
  - flush: instr_valid<=0, go to IDLE.
  - Else if decode_ready: instr_valid<=0, go to IDLE.
  - Else stay.
- FAULT: imem_req=0, instr_valid=0, fault_code held. Exit only by reset. flush and fetch_en are ignored.
- pc_step:
  - High for exactly one cycle: the first cycle of HOLD.
  - The PC controller samples it that cycle; the PC updates at the next edge, so IDLE always samples the advanced PC.
  - Never asserted for a flushed or faulted request.
- Throughput: at least 3 cycles per instruction (IDLE, REQ with ready, HOLD with decode_ready).
- Latency: instr_valid rises on the edge after the imem_ready cycle.
- A flush in HOLD after pc_step has fired is legal: the controller's redirect (PS=10/11) overrides the increment.
- Counter width: ceil(log2(WAIT_MAX+1)). No wrap is possible because the fault fires first.
- Address arithmetic is never performed here; PC+4 is the PC block's job.

Test Plan:
- Basic fetch:
  - Stimulus: reset 2 cycles, PC=0x100, fetch_en=1, memory ready 1 cycle after req with rdata=0x8B020020, decode_ready=1.
  - Response: imem_req=1 with imem_addr=0x100 for 2 cycles; then instr=0x8B020020, instr_pc=0x100, instr_valid=1 for 1 cycle; pc_step one pulse; next fetch addr=0x104.
- Decode backpressure:
  - Stimulus: as above, but decode_ready=0 for 3 HOLD cycles, then 1.
  - Response: instr_valid high 4 cycles with instr stable; pc_step pulses once; no imem_req during HOLD.
- Flush collision:
  - Stimulus: flush=1 in the same REQ cycle as imem_ready=1.
  - Response: instr_valid stays 0, pc_step stays 0, IDLE next cycle, fault_code=00.
- Misaligned PC:
  - Stimulus: PC=0x102, fetch_en=1.
  - Response: imem_req never asserts; fault_code=01 from next cycle and held with fetch_en toggling; cleared only by reset.
- Timeout:
  - Stimulus: imem_ready held 0.
  - Response: imem_req high exactly 15 cycles, then 0; fault_code=10.
- Reset mid-operation:
  - Stimulus: reset=1 while in HOLD with instr_valid=1.
  - Response: after that edge, instr_valid=0, instr=0, pc_step=0, state IDLE; fetch resumes normally after reset drops.
